gpio_mmio_controller: RTL and testbench
=======================================

Name: gpio_mmio_controller

Overview:
Parametrised memory-mapped GPIO peripheral for the pipelined RISC-V core, and the successor to the fixed 9-bit GPIO block. It sits on the MEM-stage address decoder's GPIO strobes alongside Data_Memory. It adds configurable port width, per-pin direction, input synchronisation, atomic set/clear/toggle, and edge-triggered interrupts. Read data is registered so it lines up with the MEM/WB pipeline register.

Parameters:
WIDTH, 9, number of GPIO pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (2..4)
IRQ_BOTH_EDGES, 0, 0 = rising edges only raise status; 1 = any change raises status

Ports:
clk  input  1  system clock, all flops rising-edge
reset  input  1  asynchronous, active-low reset
Mem_Read_i  input  1  read strobe from the GPIO decoder
Mem_Write_i  input  1  write strobe from the GPIO decoder
Addr_i  input  32  byte address; only bits [4:2] decoded
Write_Data_i  input  32  store data (rs2 from EX/MEM)
Read_Data_o  output  32  registered read data
gpio_port_in_i  input  WIDTH  asynchronous external pins
gpio_port_out_o  output  WIDTH  DATA_OUT register
gpio_oe_o  output  WIDTH  DIR register (1 = drive)
irq_o  output  1  level interrupt = |(IRQ_STATUS & IRQ_EN)

Behaviour:
- Reset (reset = 0, async): DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, sync chain, prev-sample, arm counter, Read_Data_o all 0. Therefore gpio_port_out_o = 0, gpio_oe_o = 0, irq_o = 0.
- Register map, offset = Addr_i[4:2]; Addr_i[1:0] and [31:5] ignored:
  - 0 DATA_OUT: RW.
  - 1 DIR: RW.
  - 2 DATA_IN: RO, synchronised pins, read regardless of DIR.
  - 3 SET: WO, DATA_OUT |= wd.
  - 4 CLR: WO, DATA_OUT &= ~wd.
  - 5 TOGGLE: WO, DATA_OUT ^= wd.
  - 6 IRQ_EN: RW.
  - 7 IRQ_STATUS: R / W1C.
- Width rules:
  - Only wd[WIDTH-1:0] is used; upper write bits are ignored.
  - Reads zero-extend to 32 bits.
  - Reads of WO offsets (3, 4, 5) return 0.
- Write timing: registers update on the clk edge where Mem_Write_i = 1.
- Read timing:
  - Read_Data_o is loaded on the edge where Mem_Read_i = 1, giving one-cycle latency.
  - Read_Data_o holds its value when Mem_Read_i = 0.
  - Mem_Read_i and Mem_Write_i both high to the same offset: the read returns the pre-write value, and the write still takes effect.
- Synchroniser and edge detection:
  - SYNC_STAGES-deep flop chain per pin; sync_q is the last stage. prev_q <= sync_q every cycle.
  - Edge term: rising = sync_q & ~prev_q; change = sync_q ^ prev_q, selected by IRQ_BOTH_EDGES.
  - IRQ_STATUS[i] is set on the edge after the detection term goes high. A pin stable from edge k is first visible in DATA_IN reads sampled at edge k+SYNC_STAGES, and its status bit sets at edge k+SYNC_STAGES+1.
  - Status bits are set regardless of IRQ_EN; IRQ_EN gates only irq_o.
- Arm counter:
  - A saturating counter counts SYNC_STAGES+1 cycles after reset release.
  - Edge detection is suppressed until it saturates, so pins held high through reset never raise a false edge.
- W1C collision: in the same cycle, a set from a new edge wins over a W1C clear of the same bit.
- irq_o is combinational from flops only (IRQ_STATUS, IRQ_EN). It changes on the same edge as those registers.
- A pin glitch shorter than one clk period may be missed; this is acceptable.
- Reset asserted mid-operation returns everything to reset values immediately, and the arm counter restarts.

Test Plan:
- Reset with gpio_port_in_i = 9'h1FF held high, release, wait 10 cycles -> IRQ_STATUS reads 0, irq_o = 0, DATA_IN reads 0x1FF.
- Write DATA_OUT = 0x0F0, SET 0x003, CLR 0x010, TOGGLE 0x101 -> DATA_OUT reads 0x1E2 and gpio_port_out_o = 9'h1E2. Write DIR = 0xFFFFFFFF -> DIR reads 0x1FF.
- IRQ_EN = 0x004, drive pin 2 from 0 to 1 before edge k -> IRQ_STATUS[2] = 1 and irq_o = 1 from edge k+3. W1C 0x004 -> irq_o = 0 the next cycle.
- IRQ_BOTH_EDGES = 0, drive pin 5 from 1 to 0 -> IRQ_STATUS stays 0. With IRQ_BOTH_EDGES = 1, the same stimulus sets bit 5.
- W1C of bit 3 in the same cycle its rising edge is detected -> IRQ_STATUS[3] remains 1.
- Mem_Read_i = Mem_Write_i = 1 to DATA_OUT (old value 0x055, new 0x0AA) -> Read_Data_o = 0x055 next cycle, and a following read returns 0x0AA. A read of offset 4 returns 0.

Source files
------------

// File: rtl/gpio_mmio_controller.sv
// Memory-mapped GPIO peripheral: output/direction registers with atomic
// set/clear/toggle, a synchronised input path, and edge-triggered interrupt
// status with write-one-to-clear. Read data is registered (one-cycle latency).
module gpio_mmio_controller #(
  parameter int WIDTH          = 9,
  parameter int SYNC_STAGES    = 2,
  parameter int IRQ_BOTH_EDGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Mem_Read_i,
  input  logic             Mem_Write_i,
  input  logic [31:0]      Addr_i,
  input  logic [31:0]      Write_Data_i,
  output logic [31:0]      Read_Data_o,
  input  logic [WIDTH-1:0] gpio_port_in_i,
  output logic [WIDTH-1:0] gpio_port_out_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  localparam logic [2:0] OFF_DATA_OUT   = 3'd0;
  localparam logic [2:0] OFF_DIR        = 3'd1;
  localparam logic [2:0] OFF_DATA_IN    = 3'd2;
  localparam logic [2:0] OFF_SET        = 3'd3;
  localparam logic [2:0] OFF_CLR        = 3'd4;
  localparam logic [2:0] OFF_TOGGLE     = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN     = 3'd6;
  localparam logic [2:0] OFF_IRQ_STATUS = 3'd7;

  // Arm counter is wide enough for SYNC_STAGES+1 up to 5.
  localparam int               ARM_W   = 3;
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  // Saturating increment used by the post-reset arm counter.
  function automatic logic [ARM_W-1:0] sat_inc(input logic [ARM_W-1:0] v);
    return (v == ARM_MAX) ? v : v + ARM_W'(1);
  endfunction

  // Zero-extend a pin-wide value onto the 32-bit read bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [2:0]       offset;
  logic [WIDTH-1:0] wd;
  logic             unused_bits;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_status;

  logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_term;
  logic [WIDTH-1:0] edge_q;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  logic [WIDTH-1:0] w1c_mask;
  logic [31:0]      rd_mux;

  // Only Addr_i[4:2] and Write_Data_i[WIDTH-1:0] carry meaning.
  assign offset      = Addr_i[4:2];
  assign wd          = Write_Data_i[WIDTH-1:0];
  assign unused_bits = ^{Addr_i[31:5], Addr_i[1:0], Write_Data_i};

  assign sync_q = sync_chain[SYNC_STAGES-1];
  assign armed  = (arm_cnt == ARM_MAX);

  // Input synchroniser: pins shift through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
    end else begin
      sync_chain[0] <= gpio_port_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

  // Previous synchronised sample and arm counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      prev_q  <= sync_q;
      arm_cnt <= sat_inc(arm_cnt);
    end
  end

  // Edge term: rising edges only, or any change, chosen at elaboration.
  always_comb begin
    if (IRQ_BOTH_EDGES != 0) edge_term = sync_q ^ prev_q;
    else                     edge_term = sync_q & ~prev_q;
  end

  // Registered detection, masked until the synchroniser has flushed its
  // reset contents so pins held high through reset raise no false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) edge_q <= '0;
    else        edge_q <= armed ? edge_term : '0;
  end

  // Output, direction and interrupt-enable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
    end else if (Mem_Write_i) begin
      case (offset)
        OFF_DATA_OUT: data_out <= wd;
        OFF_SET:      data_out <= data_out | wd;
        OFF_CLR:      data_out <= data_out & ~wd;
        OFF_TOGGLE:   data_out <= data_out ^ wd;
        OFF_DIR:      dir      <= wd;
        OFF_IRQ_EN:   irq_en   <= wd;
        default:      ;
      endcase
    end
  end

  // Write-one-to-clear mask for the status register.
  always_comb begin
    w1c_mask = '0;
    if (Mem_Write_i && offset == OFF_IRQ_STATUS) w1c_mask = wd;
  end

  // Status bits: a fresh edge wins over a simultaneous W1C of the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_status <= '0;
    else        irq_status <= (irq_status & ~w1c_mask) | edge_q;
  end

  // Read mux over pre-write register values; write-only offsets read 0.
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_DATA_OUT:   rd_mux = zext(data_out);
      OFF_DIR:        rd_mux = zext(dir);
      OFF_DATA_IN:    rd_mux = zext(sync_q);
      OFF_IRQ_EN:     rd_mux = zext(irq_en);
      OFF_IRQ_STATUS: rd_mux = zext(irq_status);
      default:        rd_mux = '0;
    endcase
  end

  // Registered read data, held while no read is strobed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          Read_Data_o <= '0;
    else if (Mem_Read_i) Read_Data_o <= rd_mux;
  end

  assign gpio_port_out_o = data_out;
  assign gpio_oe_o       = dir;
  assign irq_o           = |(irq_status & irq_en);

endmodule

// File: tb/tb_gpio_mmio_controller.sv
// Self-checking bench for gpio_mmio_controller: two instances (rising-only and
// any-change interrupts) share one bus and pin set; a history-based model
// predicts every output each cycle, plus directed literal checks.
module tb_gpio_mmio_controller;
  localparam int W = 9;
  localparam int S = 2;

  logic          clk;
  logic          reset;
  logic          mr, mw;
  logic [31:0]   addr, wd;
  logic [W-1:0]  pin;
  logic [31:0]   rd0, rd1;
  logic [W-1:0]  out0, oe0, out1, oe1;
  logic          irq0, irq1;

  int checks = 0;
  int fails  = 0;

  // Model state
  logic [W-1:0]  m_out, m_dir, m_en;
  logic [W-1:0]  m_st [2];
  logic [31:0]   m_rd [2];
  logic [W-1:0]  hist [$];   // hist[0] = pin value sampled at the latest edge
  int            since_rel;

  gpio_mmio_controller #(.WIDTH(W), .SYNC_STAGES(S), .IRQ_BOTH_EDGES(0)) dut0 (
    .clk(clk), .reset(reset), .Mem_Read_i(mr), .Mem_Write_i(mw),
    .Addr_i(addr), .Write_Data_i(wd), .Read_Data_o(rd0),
    .gpio_port_in_i(pin), .gpio_port_out_o(out0), .gpio_oe_o(oe0), .irq_o(irq0));

  gpio_mmio_controller #(.WIDTH(W), .SYNC_STAGES(S), .IRQ_BOTH_EDGES(1)) dut1 (
    .clk(clk), .reset(reset), .Mem_Read_i(mr), .Mem_Write_i(mw),
    .Addr_i(addr), .Write_Data_i(wd), .Read_Data_o(rd1),
    .gpio_port_in_i(pin), .gpio_port_out_o(out1), .gpio_oe_o(oe1), .irq_o(irq1));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = '0;
      m_rd[i] = '0;
    end
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back('0);
    since_rel = 0;
  endtask

  // One clock edge of the peripheral, from the pin history and bus inputs.
  // A change first sampled at edge k shows in DATA_IN reads at edge k+S and
  // sets status at edge k+S+1; transitions in the first S+1 edges after
  // reset release are ignored.
  task automatic model_step();
    logic [W-1:0] din, newer, older, w1c, term;
    logic [2:0]   off;
    logic [31:0]  rv;
    logic         armed;
    since_rel++;
    din   = hist[S-1];
    newer = hist[S];
    older = hist[S+1];
    armed = (since_rel >= S + 3);
    off   = addr[4:2];
    for (int i = 0; i < 2; i++) begin
      rv = 32'd0;
      case (off)
        3'd0: rv[W-1:0] = m_out;
        3'd1: rv[W-1:0] = m_dir;
        3'd2: rv[W-1:0] = din;
        3'd6: rv[W-1:0] = m_en;
        3'd7: rv[W-1:0] = m_st[i];
        default: rv = 32'd0;
      endcase
      if (mr) m_rd[i] = rv;
    end
    w1c = (mw && off == 3'd7) ? wd[W-1:0] : '0;
    for (int i = 0; i < 2; i++) begin
      term = (i == 0) ? (newer & ~older) : (newer ^ older);
      m_st[i] = (m_st[i] & ~w1c) | (armed ? term : '0);
    end
    if (mw) begin
      case (off)
        3'd0: m_out = wd[W-1:0];
        3'd1: m_dir = wd[W-1:0];
        3'd3: m_out = m_out | wd[W-1:0];
        3'd4: m_out = m_out & ~wd[W-1:0];
        3'd5: m_out = m_out ^ wd[W-1:0];
        3'd6: m_en  = wd[W-1:0];
        default: ;
      endcase
    end
    hist.push_front(pin);
    void'(hist.pop_back());
  endtask

  task automatic compare_all();
    chk("port_out0", out0, m_out);
    chk("oe0",       oe0,  m_dir);
    chk("irq0",      irq0, |(m_st[0] & m_en));
    chk("rdata0",    rd0,  m_rd[0]);
    chk("port_out1", out1, m_out);
    chk("oe1",       oe1,  m_dir);
    chk("irq1",      irq1, |(m_st[1] & m_en));
    chk("rdata1",    rd1,  m_rd[1]);
  endtask

  // Drive one bus cycle, step the model at the edge, check on the falling edge.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mr = r; mw = w; addr = a; wd = d;
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    compare_all();
    mr = 1'b0; mw = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Directed sequence followed by randomized traffic
  initial begin
    reset = 1'b0;
    mr = 1'b0; mw = 1'b0; addr = '0; wd = '0;
    pin = '1;
    model_reset();
    idle(3);
    chk("reset_port_out", out0, 32'd0);
    chk("reset_irq", irq0, 32'd0);
    reset = 1'b1;

    // Pins held high through reset raise no status
    idle(10);
    cyc(1'b1, 1'b0, 32'h1C, 32'd0);
    chk("lit_status_after_reset", rd0, 32'd0);
    chk("lit_status_after_reset_any", rd1, 32'd0);
    chk("lit_irq_after_reset", irq0, 32'd0);
    cyc(1'b1, 1'b0, 32'h08, 32'd0);
    chk("lit_data_in_high", rd0, 32'h1FF);

    // Atomic set/clear/toggle
    cyc(1'b0, 1'b1, 32'h00, 32'h0F0);
    cyc(1'b0, 1'b1, 32'h0C, 32'h003);
    cyc(1'b0, 1'b1, 32'h10, 32'h010);
    cyc(1'b0, 1'b1, 32'h14, 32'h101);
    cyc(1'b1, 1'b0, 32'h00, 32'd0);
    chk("lit_data_out", rd0, 32'h1E2);
    chk("lit_port_out", out0, 32'h1E2);
    cyc(1'b0, 1'b1, 32'h04, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, 32'h04, 32'd0);
    chk("lit_dir_width", rd0, 32'h1FF);

    // Rising edge on pin 2 with latency S+1, then W1C
    cyc(1'b0, 1'b1, 32'h18, 32'h004);
    pin = '0;
    idle(6);
    cyc(1'b0, 1'b1, 32'h1C, 32'h1FF);
    pin[2] = 1'b1;
    idle(3);
    chk("lit_irq_before_k3", irq0, 32'd0);
    idle(1);
    chk("lit_irq_at_k3", irq0, 32'd1);
    cyc(1'b0, 1'b1, 32'h1C, 32'h004);
    chk("lit_irq_after_w1c", irq0, 32'd0);

    // Falling edge on pin 5: only the any-change instance reacts
    pin[5] = 1'b1;
    idle(6);
    cyc(1'b0, 1'b1, 32'h1C, 32'h1FF);
    pin[5] = 1'b0;
    idle(6);
    cyc(1'b1, 1'b0, 32'h1C, 32'd0);
    chk("lit_fall_rising_only", rd0, 32'd0);
    chk("lit_fall_any_change", rd1, 32'h020);

    // W1C on the same edge the pin 3 rising edge lands in status
    cyc(1'b0, 1'b1, 32'h1C, 32'h1FF);
    pin[3] = 1'b1;
    idle(3);
    cyc(1'b0, 1'b1, 32'h1C, 32'h008);
    cyc(1'b1, 1'b0, 32'h1C, 32'd0);
    chk("lit_set_beats_w1c", rd0 & 32'h8, 32'h8);

    // Simultaneous read and write returns the old value
    cyc(1'b0, 1'b1, 32'h00, 32'h055);
    cyc(1'b1, 1'b1, 32'h00, 32'h0AA);
    chk("lit_rw_old", rd0, 32'h055);
    cyc(1'b1, 1'b0, 32'h00, 32'd0);
    chk("lit_rw_new", rd0, 32'h0AA);
    cyc(1'b1, 1'b0, 32'h10, 32'd0);
    chk("lit_wo_read", rd0, 32'd0);

    // Randomized traffic with one asynchronous reset mid-run
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        chk("mid_reset_port_out", out0, 32'd0);
        idle(2);
        reset = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) pin = W'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
